// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared types and geometry constants for the Me_engine load controller
package me_pkg;

  typedef enum logic [2:0] {
    LOAD_CUR,
    LOAD_REF,
    GO,
    WAIT,
    RESULT
  } state_t;

  localparam int PIX_W     = 8;
  localparam int PACK      = 8;
  localparam int CUR_DIM   = 16;
  localparam int REF_DIM   = 32;
  localparam int MV_W      = 8;
  localparam int WORD_W    = PIX_W * PACK;
  localparam int CUR_WORDS = CUR_DIM * CUR_DIM / PACK;
  localparam int REF_WORDS = REF_DIM * REF_DIM / PACK;

endpackage

// File: rtl/me_pix_packer.sv
// rtl/me_pix_packer.sv - packs accepted pixels LSB-first into words, one-cycle word_valid pulse
module me_pix_packer
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_accept,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              word_start,
  output logic              word_last,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  localparam int IDX_W = $clog2(PACK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK - 1);

  logic [IDX_W-1:0]        idx;
  logic [WORD_W-PIX_W-1:0] acc;

  assign word_start = (idx == '0);
  assign word_last  = pix_accept && (idx == IDX_LAST);

  // The final pixel bypasses acc so the full word is registered in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      acc        <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (pix_accept) begin
        if (idx == IDX_LAST) begin
          word_data  <= {pix_data, acc};
          word_valid <= 1'b1;
          idx        <= '0;
        end else begin
          acc[idx*PIX_W +: PIX_W] <= pix_data;
          idx                     <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/me_load_ctrl.sv
// rtl/me_load_ctrl.sv - loads Me_engine cur/ref memories, starts search, returns mv (opt: ME_LOAD_PERF_EN)
module me_load_ctrl
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        range_in,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic [4:0]        address_write_cur,
  output logic [WORD_W-1:0] data_write_cur,
  output logic              write_enable_cur,
  output logic [6:0]        address_write_ref,
  output logic [WORD_W-1:0] data_write_ref,
  output logic              write_enable_ref,
  output logic [1:0]        r,
  output logic              go,
  input  logic              done,
  input  logic [MV_W-1:0]   m_i,
  input  logic [MV_W-1:0]   m_j,
  output logic              mv_valid,
  input  logic              mv_ready,
  output logic [MV_W-1:0]   mv_i,
  output logic [MV_W-1:0]   mv_j,
  output logic [15:0]       blk_cnt
`ifdef ME_LOAD_PERF_EN
  ,
  output logic [15:0]       search_cycles
`endif
);

  localparam logic [6:0] CUR_LAST = 7'(CUR_WORDS - 1);
  localparam logic [6:0] REF_LAST = 7'(REF_WORDS - 1);

  state_t              state, state_nxt;
  logic                load_nxt;
  logic                pix_accept;
  logic                word_start, word_last, word_valid;
  logic [WORD_W-1:0]   word_data;
  logic [6:0]          wcnt;
  logic [6:0]          wr_addr;
  logic                wr_is_ref;

  assign pix_accept = pix_valid && pix_ready;

  me_pix_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .pix_accept (pix_accept),
    .pix_data   (pix_data),
    .word_start (word_start),
    .word_last  (word_last),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD_CUR;
    else       state <= state_nxt;
  end

  // Phase changes on the last pixel, not on its write, so LOAD_REF accepts with no bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_CUR: if (word_last && wcnt == CUR_LAST) state_nxt = LOAD_REF;
      LOAD_REF: if (word_last && wcnt == REF_LAST) state_nxt = GO;
      GO:       state_nxt = WAIT;
      WAIT:     if (done) state_nxt = RESULT;
      RESULT:   if (mv_ready) state_nxt = LOAD_CUR;
      default:  state_nxt = LOAD_CUR;
    endcase
  end

  always_comb begin
    load_nxt = (state_nxt == LOAD_CUR) || (state_nxt == LOAD_REF);
    mv_valid = (state == RESULT);
  end

  // pix_ready is registered so it reads 0 while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_ready <= 1'b0;
      wcnt      <= '0;
      wr_addr   <= '0;
      wr_is_ref <= 1'b0;
      r         <= '0;
      go        <= 1'b0;
      mv_i      <= '0;
      mv_j      <= '0;
      blk_cnt   <= '0;
    end else begin
      pix_ready <= load_nxt;
      go        <= (state == GO);
      if (word_last) begin
        wr_addr   <= wcnt;
        wr_is_ref <= (state == LOAD_REF);
        if ((state == LOAD_CUR && wcnt == CUR_LAST) || (state == LOAD_REF && wcnt == REF_LAST))
          wcnt <= '0;
        else
          wcnt <= wcnt + 7'd1;
      end
      if (state == LOAD_CUR && pix_accept && word_start && wcnt == '0)
        r <= range_in;
      if (state == WAIT && done) begin
        mv_i <= m_i;
        mv_j <= m_j;
      end
      if (state == RESULT && mv_ready)
        blk_cnt <= blk_cnt + 16'd1;
    end
  end

  assign address_write_cur = wr_addr[4:0];
  assign address_write_ref = wr_addr;
  assign data_write_cur    = word_data;
  assign data_write_ref    = word_data;
  assign write_enable_cur  = word_valid && !wr_is_ref;
  assign write_enable_ref  = word_valid && wr_is_ref;

`ifdef ME_LOAD_PERF_EN
  logic [15:0] perf_cnt;

  // Cleared while go is being launched, so the go cycle itself counts as distance 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt      <= '0;
      search_cycles <= '0;
    end else begin
      if (state == GO)
        perf_cnt <= '0;
      else if (state == WAIT && perf_cnt != 16'hFFFF)
        perf_cnt <= perf_cnt + 16'd1;
      if (state == WAIT && done)
        search_cycles <= perf_cnt;
    end
  end
`endif

endmodule
